// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : MEM-stage load/store unit. Accepts one load or store per
//               instruction from EX/MEM and drives the data-side sram-like bus.
//               It holds the pipeline stalled until the access completes, then
//               returns the load data aligned and extended for MEM/WB.
// Ports       :
//   clk, rst            pipeline clock, asynchronous active-high reset
//   op_valid            MEM-stage instruction is a load or store
//   op_wr               1 = store, 0 = load
//   op_size             0 = byte, 1 = half, 2 = word, 3 = illegal
//   op_signed           loads: sign-extend (1) or zero-extend (0)
//   op_addr             byte address
//   op_wdata            store data, right-justified
//   advance             MEM/WB captures this cycle; consumes a finished result
//   data_req/wr/size/addr/wdata   sram-like request side
//   data_rdata/addr_ok/data_ok    sram-like response side
//   rdata_o             extended load result, 0 for stores
//   stall_o             freeze PC..EX/MEM while an access is outstanding
//   addr_err_o          misaligned or illegal op; no bus request issued
// Revision    : 1.0  initial release
// ============================================================================
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_wr,
  input  logic [1:0]        op_size,
  input  logic              op_signed,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  input  logic              advance,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic [31:0]       data_rdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              addr_err_o
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;
  localparam logic [1:0] c_SZ_ILL  = 2'd3;

  logic [1:0]        state_q, state_d;

  // Captured op fields; the bus sees these so they stay stable for the whole
  // request phase even if the pipeline inputs wobble.
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              w_err;
  logic              w_accept;
  logic [31:0]       w_lanes;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;

  // --------------------------------------------------------------------------
  // Alignment check on the incoming op
  // --------------------------------------------------------------------------
  always_comb begin
    w_err = 1'b0;
    if (op_valid) begin
      case (op_size)
        c_SZ_HALF: w_err = op_addr[0];
        c_SZ_WORD: w_err = (op_addr[1:0] != 2'b00);
        c_SZ_ILL:  w_err = 1'b1;
        default:   w_err = 1'b0;
      endcase
    end
  end

  assign w_accept = (state_q == c_ST_IDLE) && op_valid && !w_err;

  // --------------------------------------------------------------------------
  // Store lane replication: every byte lane carries the data so the slave can
  // pick the lane from the address without a shifter.
  // --------------------------------------------------------------------------
  always_comb begin
    w_lanes = op_wdata;
    case (op_size)
      c_SZ_BYTE: w_lanes = {4{op_wdata[7:0]}};
      c_SZ_HALF: w_lanes = {2{op_wdata[15:0]}};
      default:   w_lanes = op_wdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load extraction and extension, using the captured low address bits
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte = data_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    w_byte = data_rdata[7:0];
      2'd1:    w_byte = data_rdata[15:8];
      2'd2:    w_byte = data_rdata[23:16];
      default: w_byte = data_rdata[31:24];
    endcase
    w_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (size_q)
      c_SZ_BYTE: w_load = {{24{signed_q & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{16{signed_q & w_half[15]}}, w_half};
      default:   w_load = data_rdata;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (w_accept)     state_d = c_ST_REQ;
      c_ST_REQ:  if (data_addr_ok) state_d = c_ST_WAIT;
      c_ST_WAIT: if (data_data_ok) state_d = c_ST_DONE;
      c_ST_DONE: if (advance)      state_d = c_ST_IDLE;
      default:                     state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wdata = 32'd0;
    stall_o    = 1'b0;
    addr_err_o = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        // Combinational terms are masked by reset so every output reads 0
        // the moment reset is asserted, whatever the pipeline presents.
        stall_o    = op_valid && !w_err && !rst;
        addr_err_o = w_err && !rst;
      end
      c_ST_REQ: begin
        data_req   = 1'b1;
        data_wr    = wr_q;
        data_size  = size_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;
        stall_o    = 1'b1;
      end
      c_ST_WAIT: begin
        stall_o    = 1'b1;
      end
      default: begin
        stall_o    = 1'b0;
      end
    endcase
  end

  assign rdata_o = rdata_q;

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_d     = wr_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (w_accept) begin
      wr_d     = op_wr;
      size_d   = op_size;
      signed_d = op_signed;
      addr_d   = op_addr;
      wdata_d  = w_lanes;
    end
    if ((state_q == c_ST_WAIT) && data_data_ok) begin
      rdata_d = wr_q ? 32'd0 : w_load;
    end else if ((state_q == c_ST_DONE) && advance) begin
      rdata_d = 32'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      wr_q     <= wr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access. Directed transactions plus
//               randomized loads/stores against a behavioural reference model
//               of the bus protocol, lane replication and load extension.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_wr;
  logic [1:0]  op_size;
  logic        op_signed;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        advance;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        addr_err_o;

  int n_checks;
  int n_errors;

  mem_access #(.ADDR_W(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_wr        (op_wr),
    .op_size      (op_size),
    .op_signed    (op_signed),
    .op_addr      (op_addr),
    .op_wdata     (op_wdata),
    .advance      (advance),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .addr_err_o   (addr_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (off % 2) != 0;
    if (sz == 2'd2) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_lanes(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] b, h;
    b = wd % 256;
    h = wd % 65536;
    if (sz == 2'd0) return b * 32'h01010101;
    if (sz == 2'd1) return h * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (sz == 2'd0) begin
      v = (rd >> (8 * off)) % 256;
      if (sgn && v >= 128) v = v - 256;
      return v;
    end
    if (sz == 2'd1) begin
      v = (rd >> (16 * (off / 2))) % 65536;
      if (sgn && v >= 32768) v = v - 65536;
      return v;
    end
    return rd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from the MEM-stage point of view. a_dly cycles
  // before addr_ok, d_dly extra WAIT cycles before data_ok, DONE held for
  // hold cycles before advance.
  task automatic do_op(input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int a_dly, input int d_dly,
                       input int hold);
    logic        err;
    logic [31:0] exp_r;
    err   = ref_err(sz, addr);
    exp_r = wr ? 32'd0 : ref_load(sz, sgn, addr, rd);

    op_valid     = 1'b1;
    op_wr        = wr;
    op_size      = sz;
    op_signed    = sgn;
    op_addr      = addr;
    op_wdata     = wd;
    advance      = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'($urandom_range(0, 1));
    data_rdata   = $urandom;
    #1;
    check_eq("idle_err", 32'(addr_err_o), 32'(err));
    check_eq("idle_stall", 32'(stall_o), 32'(!err));
    check_eq("idle_req", 32'(data_req), 32'd0);

    if (err) begin
      tick();
      data_data_ok = 1'b0;
      #1;
      check_eq("err_req", 32'(data_req), 32'd0);
      check_eq("err_stall", 32'(stall_o), 32'd0);
      check_eq("err_flag", 32'(addr_err_o), 32'd1);
      op_valid = 1'b0;
      #1;
      check_eq("err_clr", 32'(addr_err_o), 32'd0);
      return;
    end

    tick();
    for (int k = 0; k <= a_dly; k++) begin
      data_addr_ok = (k == a_dly);
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata   = $urandom;
      #1;
      check_eq("req_req", 32'(data_req), 32'd1);
      check_eq("req_wr", 32'(data_wr), 32'(wr));
      check_eq("req_size", 32'(data_size), 32'(sz));
      check_eq("req_addr", data_addr, addr);
      check_eq("req_wdata", data_wdata, ref_lanes(sz, wd));
      check_eq("req_stall", 32'(stall_o), 32'd1);
      tick();
    end

    for (int j = 0; j <= d_dly; j++) begin
      data_addr_ok = 1'($urandom_range(0, 1));
      data_data_ok = (j == d_dly);
      data_rdata   = (j == d_dly) ? rd : $urandom;
      #1;
      check_eq("wait_req", 32'(data_req), 32'd0);
      check_eq("wait_stall", 32'(stall_o), 32'd1);
      tick();
    end

    for (int h = 0; h <= hold; h++) begin
      data_addr_ok = 1'($urandom_range(0, 1));
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata   = $urandom;
      advance      = (h == hold);
      #1;
      check_eq("done_stall", 32'(stall_o), 32'd0);
      check_eq("done_req", 32'(data_req), 32'd0);
      check_eq("done_rdata", rdata_o, exp_r);
      tick();
    end

    advance      = 1'b0;
    op_valid     = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    #1;
    check_eq("post_rdata", rdata_o, 32'd0);
    check_eq("post_stall", 32'(stall_o), 32'd0);
    check_eq("post_req", 32'(data_req), 32'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    op_valid     = 1'b0;
    op_wr        = 1'b0;
    op_size      = 2'd0;
    op_signed    = 1'b0;
    op_addr      = 32'd0;
    op_wdata     = 32'd0;
    advance      = 1'b0;
    data_rdata   = 32'd0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(data_req), 32'd0);
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_err", 32'(addr_err_o), 32'd0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_op(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    do_op(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80112233, 0, 0, 0);
    do_op(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80112233, 0, 0, 0);
    do_op(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h80011234, 0, 0, 0);
    do_op(1'b1, 2'd0, 1'b0, 32'h2001, 32'h000000A5, 32'h12345678, 0, 0, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 32'h0, 0, 0, 0);
    do_op(1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, 32'h0, 0, 0, 0);
    do_op(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 32'h0, 0, 0, 0);
    do_op(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'hCAFEF00D, 4, 2, 2);

    // Reset while the access sits in WAIT
    op_valid  = 1'b1;
    op_wr     = 1'b0;
    op_size   = 2'd2;
    op_signed = 1'b0;
    op_addr   = 32'h3000;
    #1;
    tick();
    data_addr_ok = 1'b1;
    #1;
    check_eq("rw_req", 32'(data_req), 32'd1);
    tick();
    data_addr_ok = 1'b0;
    #1;
    check_eq("rw_wait_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rw_rst_stall", 32'(stall_o), 32'd0);
    check_eq("rw_rst_req", 32'(data_req), 32'd0);
    check_eq("rw_rst_addr", data_addr, 32'd0);
    check_eq("rw_rst_rdata", rdata_o, 32'd0);
    tick();
    op_valid     = 1'b0;
    rst          = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h55555555;
    #1;
    check_eq("rw_stray_stall", 32'(stall_o), 32'd0);
    tick();
    data_data_ok = 1'b0;
    #1;
    check_eq("rw_stray_req", 32'(data_req), 32'd0);
    check_eq("rw_stray_rdata", rdata_o, 32'd0);
    do_op(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0, 32'h0BADCAFE, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
            $urandom, $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
